video_wr_arbiter: RTL and testbench
===================================

Name: video_wr_arbiter

Overview:
- Round-robin write scheduler shared by the 4 per-channel video sampling buffers.
- Latches each channel's ready request and grants one channel at a time.
- For the granted channel: issues one write command to the DDR write port, then streams BURST_LEN beats read from that channel's buffer half.
- Keeps a per-channel DDR write offset, which wraps at frame end.

Parameters:
DQ_WIDTH, 32, DDR DQ width; one beat = DQ_WIDTH*8 bits
RD_ADDR_LEN, 5, channel buffer read address width (2 halves of BURST_LEN)
BURST_LEN, 16, beats per burst; must equal 2^(RD_ADDR_LEN-1)
ADDR_WIDTH, 28, DDR command address width, in beat units
CH_REGION, 28'h0040000, beats reserved per channel; channel i base = i*CH_REGION

Ports:
clk_in  in  1  clock; channel buffer rd_clk is tied to clk_in
rst  in  1  reset
cfg_en  in  1  arbitration enable
ch_ready  in  4  per-channel data_out_ready
ch_frame_end  in  4  per-channel frame_end_flag pulse
ch_rd_data  in  4*DQ_WIDTH*8  channel read data; channel i at [i*DQ_WIDTH*8 +: DQ_WIDTH*8]
ch_rd_valid  out  4  per-channel read window (half-select edge to buffer)
ch_rd_addr  out  RD_ADDR_LEN  shared read address
wr_cmd_valid  out  1  DDR write command valid
wr_cmd_ready  in  1  DDR write command accept
wr_cmd_addr  out  ADDR_WIDTH  burst start address, beats
wr_cmd_len  out  8  BURST_LEN-1
wr_data_valid  out  1  beat valid
wr_data_ready  in  1  beat accept
wr_data  out  DQ_WIDTH*8  beat data
wr_data_last  out  1  final beat of burst
grant_id  out  2  currently/last granted channel
frame_wrap  out  4  one-cycle pulse when a channel's offset is reset to 0

Behaviour:
- Interface:
  - Reset rst, asynchronous, active-low; clock clk_in.
  - All outputs and state reset to 0.
  - FSM resets to IDLE; rr pointer resets to 0.
  - Mid-operation reset abandons any burst; no completion is signalled.
- Request latch:
  - pend[i] is set on any cycle with ch_ready[i]=1.
  - pend[i] is cleared on the cycle channel i is granted; a set in that same cycle wins.
  - fpend[i] is set on ch_frame_end[i]; it is consumed at DONE of channel i.
- Per-channel half bit half[i] toggles after every completed burst of channel i. Read base = half[i]*BURST_LEN.
- FSM:
  - IDLE: if cfg_en and any pend, go to ARB; otherwise stay.
  - ARB (1 cycle):
    - Grant the first pend channel searching rr, rr+1, ... mod 4.
    - Set grant_id, clear pend[grant], go to CMD.
  - CMD:
    - wr_cmd_valid=1.
    - wr_cmd_addr = grant*CH_REGION + off[grant] (ADDR_WIDTH, truncating); wr_cmd_len = BURST_LEN-1.
    - ch_rd_valid[grant]=1; ch_rd_addr = base+0 (prefetch).
    - On wr_cmd_ready, go to DATA.
  - DATA:
    - wr_data_valid=1; wr_data = ch_rd_data of grant (registered read, 1-cycle latency).
    - ch_rd_addr = base + beat + (wr_data_valid & wr_data_ready), combinational, giving full throughput.
    - beat increments on each accept.
    - wr_data_last=1 when beat==BURST_LEN-1. An accept of last goes to DONE.
    - wr_data holds stable while valid and not ready.
    - ch_rd_valid[grant] stays 1 for all of CMD and DATA.
  - DONE (1 cycle):
    - ch_rd_valid cleared; toggle half[grant]; rr = grant+1 mod 4.
    - If fpend[grant]: off[grant]=0, clear fpend, pulse frame_wrap[grant].
    - Otherwise off[grant] += BURST_LEN, wrapping to 0 when the result reaches CH_REGION; the wrap also pulses frame_wrap.
    - Go to IDLE.
- cfg_en=0:
  - Does not interrupt a burst.
  - Blocks new grants only; pend keeps accumulating.
- Minimum gap between bursts is 3 cycles (DONE, IDLE, ARB).
- Only one ch_rd_valid bit is ever high.

Test Plan:
- Single channel: ch_ready[2] pulse, cmd/data ready held 1 -> one command with addr=2*CH_REGION=0x0080000, len=15. Then 16 beats on consecutive cycles, ch_rd_addr 0..15, last on beat 15. off[2]=16, half[2]=1.
- Round robin: ch_ready=4'b1111 in one cycle -> grants in order 0,1,2,3, each a full 16-beat burst; next request from ch0 with rr=0 is served with rd_addr 16..31.
- Backpressure: wr_data_ready toggles 1,0,1,0 -> wr_data stable while stalled, no beat duplicated or skipped, exactly 16 accepts; wr_cmd_ready held 0 for 5 cycles -> wr_cmd_valid and addr stay stable.
- Frame end: ch_frame_end[1] pulses mid-burst of ch1 at off=0x120 -> at DONE off[1]=0 and frame_wrap[1] pulses once; the next ch1 command addr is 0x0040000.
- Region wrap: off[3] = CH_REGION-16 -> after the burst, off[3]=0 and frame_wrap[3]=1.
- Reset and enable: rst low during beat 7 -> all outputs 0 immediately and FSM in IDLE. cfg_en=0 with pend=4'b0101 -> no wr_cmd_valid; raising cfg_en grants ch0 then ch2.

Source files
------------

// File: rtl/video_wr_arbiter.sv
// Round-robin DDR write scheduler for the four per-channel video sampling buffers.
// Each grant issues one write command, then streams one BURST_LEN-beat half of the channel buffer.
module video_wr_arbiter #(
  parameter int                    DQ_WIDTH    = 32,
  parameter int                    RD_ADDR_LEN = 5,
  parameter int                    BURST_LEN   = 16,
  parameter int                    ADDR_WIDTH  = 28,
  parameter logic [ADDR_WIDTH-1:0] CH_REGION   = 28'h0040000
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     cfg_en,
  input  logic [3:0]               ch_ready,
  input  logic [3:0]               ch_frame_end,
  input  logic [4*DQ_WIDTH*8-1:0]  ch_rd_data,
  output logic [3:0]               ch_rd_valid,
  output logic [RD_ADDR_LEN-1:0]   ch_rd_addr,
  output logic                     wr_cmd_valid,
  input  logic                     wr_cmd_ready,
  output logic [ADDR_WIDTH-1:0]    wr_cmd_addr,
  output logic [7:0]               wr_cmd_len,
  output logic                     wr_data_valid,
  input  logic                     wr_data_ready,
  output logic [DQ_WIDTH*8-1:0]    wr_data,
  output logic                     wr_data_last,
  output logic [1:0]               grant_id,
  output logic [3:0]               frame_wrap
);
  localparam int NCH = 4;
  localparam int BW  = DQ_WIDTH*8;
  localparam int BTW = RD_ADDR_LEN-1;

  typedef enum logic [2:0] {IDLE, ARB, CMD, DATA, DONE} state_t;

  state_t                          state_q;
  logic [NCH-1:0]                  pend_q, fpend_q, half_q, rd_vld_q;
  logic [NCH-1:0][ADDR_WIDTH-1:0]  off_q;
  logic [1:0]                      rr_q, grant_q, gnt_d, idx;
  logic [BTW-1:0]                  beat_q;
  logic                            cmd_vld_q, dat_vld_q;
  logic [ADDR_WIDTH-1:0]           cmd_addr_q, cmd_addr_d, off_sum, off_d;
  logic [NCH-1:0]                  pend_clr, fp_clr;
  logic                            wrap_d, accept, last_beat;

  // Reverse scan so the nearest pending channel at or after rr wins.
  always_comb begin
    gnt_d = rr_q;
    idx   = rr_q;
    for (int k = NCH-1; k >= 0; k--) begin
      idx = rr_q + 2'(k);
      if (pend_q[idx]) gnt_d = idx;
    end
  end

  always_comb begin
    cmd_addr_d = ADDR_WIDTH'(gnt_d) * CH_REGION + off_q[gnt_d];
    off_sum    = off_q[grant_q] + ADDR_WIDTH'(BURST_LEN);
    wrap_d     = fpend_q[grant_q] || (off_sum >= CH_REGION);
    off_d      = wrap_d ? '0 : off_sum;
    pend_clr   = (state_q == ARB)  ? (NCH'(1) << gnt_d)   : '0;
    fp_clr     = (state_q == DONE) ? (NCH'(1) << grant_q) : '0;
    accept     = dat_vld_q & wr_data_ready;
    last_beat  = (beat_q == BTW'(BURST_LEN-1));
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      fpend_q    <= '0;
      half_q     <= '0;
      rd_vld_q   <= '0;
      off_q      <= '0;
      rr_q       <= '0;
      grant_q    <= '0;
      beat_q     <= '0;
      cmd_vld_q  <= 1'b0;
      dat_vld_q  <= 1'b0;
      cmd_addr_q <= '0;
    end else begin
      pend_q  <= (pend_q & ~pend_clr) | ch_ready;
      fpend_q <= (fpend_q & ~fp_clr) | ch_frame_end;
      case (state_q)
        IDLE: if (cfg_en && |pend_q) state_q <= ARB;
        ARB: begin
          grant_q    <= gnt_d;
          cmd_addr_q <= cmd_addr_d;
          cmd_vld_q  <= 1'b1;
          rd_vld_q   <= NCH'(1) << gnt_d;
          state_q    <= CMD;
        end
        CMD: if (wr_cmd_ready) begin
          cmd_vld_q <= 1'b0;
          dat_vld_q <= 1'b1;
          beat_q    <= '0;
          state_q   <= DATA;
        end
        DATA: if (wr_data_ready) begin
          beat_q <= beat_q + 1'b1;
          if (last_beat) begin
            dat_vld_q <= 1'b0;
            rd_vld_q  <= '0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          half_q[grant_q] <= ~half_q[grant_q];
          off_q[grant_q]  <= off_d;
          rr_q            <= grant_q + 2'd1;
          state_q         <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read address runs one beat ahead on accept so the registered buffer read keeps up.
  always_comb begin
    ch_rd_addr = '0;
    if (cmd_vld_q)      ch_rd_addr = {half_q[grant_q], {BTW{1'b0}}};
    else if (dat_vld_q) ch_rd_addr = {half_q[grant_q], beat_q} + RD_ADDR_LEN'(accept);
  end

  assign ch_rd_valid   = rd_vld_q;
  assign wr_cmd_valid  = cmd_vld_q;
  assign wr_cmd_addr   = cmd_addr_q;
  assign wr_cmd_len    = cmd_vld_q ? 8'(BURST_LEN-1) : 8'd0;
  assign wr_data_valid = dat_vld_q;
  assign wr_data       = dat_vld_q ? ch_rd_data[grant_q*BW +: BW] : '0;
  assign wr_data_last  = dat_vld_q & last_beat;
  assign grant_id      = grant_q;
  assign frame_wrap    = (state_q == DONE && wrap_d) ? (NCH'(1) << grant_q) : '0;
endmodule

// File: tb/tb_video_wr_arbiter.sv
// Scoreboarded random bench for video_wr_arbiter: a burst-level model predicts grant order,
// command addresses, buffer halves and wrap pulses; a negedge monitor checks what the DUT emits.
module tb_video_wr_arbiter;
  localparam int         BW  = 256;
  localparam int         RAL = 5;
  localparam int         BL  = 16;
  // Small region so offset wrap is reachable in a short run.
  localparam logic [27:0] REG = 28'h0000100;

  logic            clk_in = 1'b0, rst = 1'b0, cfg_en = 1'b0;
  logic [3:0]      ch_ready = '0, ch_frame_end = '0;
  logic [3:0][BW-1:0] rdq;
  logic [3:0]      ch_rd_valid, frame_wrap;
  logic [RAL-1:0]  ch_rd_addr;
  logic            wr_cmd_valid, wr_cmd_ready = 1'b1, wr_data_valid, wr_data_ready = 1'b1, wr_data_last;
  logic [27:0]     wr_cmd_addr;
  logic [7:0]      wr_cmd_len;
  logic [BW-1:0]   wr_data;
  logic [1:0]      grant_id;

  video_wr_arbiter #(.DQ_WIDTH(32), .RD_ADDR_LEN(RAL), .BURST_LEN(BL), .ADDR_WIDTH(28), .CH_REGION(REG)) dut (
    .clk_in(clk_in), .rst(rst), .cfg_en(cfg_en), .ch_ready(ch_ready), .ch_frame_end(ch_frame_end),
    .ch_rd_data(rdq), .ch_rd_valid(ch_rd_valid), .ch_rd_addr(ch_rd_addr),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data), .wr_data_last(wr_data_last),
    .grant_id(grant_id), .frame_wrap(frame_wrap));

  always #5 clk_in = ~clk_in;

  typedef struct { logic [1:0] ch; logic [27:0] addr; logic half; } exp_t;
  exp_t          expq[$];
  int            checks = 0, errors = 0;
  int            m_off[4], exp_wrap[4], wrap_cnt[4];
  bit            m_half[4], m_fp[4];
  int            m_rr = 0, bursts_done = 0, bursts_exp = 0, mon_beat = 0, bp_mode = 0, cmd_wait = 0;
  logic [BW-1:0] mem[4][32];

  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", n, a, e);
    end
  endtask

  // Channel buffer: registered read, 1-cycle latency.
  always @(posedge clk_in)
    for (int i = 0; i < 4; i++) if (ch_rd_valid[i]) rdq[i] <= mem[i][ch_rd_addr];

  always begin
    @(posedge clk_in); #1;
    case (bp_mode)
      0: begin wr_cmd_ready = 1'b1; wr_data_ready = 1'b1; end
      1: begin wr_cmd_ready = 1'($urandom_range(0, 1)); wr_data_ready = ($urandom_range(0, 3) != 0); end
      default: begin
        wr_data_ready = ~wr_data_ready;
        cmd_wait      = wr_cmd_valid ? cmd_wait + 1 : 0;
        wr_cmd_ready  = (cmd_wait > 5);
      end
    endcase
  end

  // Monitor
  logic          p_cmd_stall = 0, p_dat_stall = 0, have_cur = 0;
  logic [27:0]   p_addr;
  logic [BW-1:0] p_data;
  exp_t          cur;
  always @(negedge clk_in) begin
    if (!rst) begin
      have_cur = 0; p_cmd_stall = 0; p_dat_stall = 0; mon_beat = 0;
    end else begin
      chk("rd_valid_onehot0", 256'($onehot0(ch_rd_valid)), 256'(1));
      for (int i = 0; i < 4; i++) if (frame_wrap[i]) wrap_cnt[i]++;
      if (p_cmd_stall) chk("cmd_valid_held", 256'(wr_cmd_valid), 256'(1));
      if (wr_cmd_valid) begin
        if (p_cmd_stall) chk("cmd_addr_stable", 256'(wr_cmd_addr), 256'(p_addr));
        if (wr_cmd_ready) begin
          if (expq.size() == 0) chk("unexpected_cmd", 256'(wr_cmd_addr), 256'(0) - 256'(1));
          else begin
            cur = expq.pop_front(); have_cur = 1; mon_beat = 0;
            chk("grant_id", 256'(grant_id), 256'(cur.ch));
            chk("cmd_addr", 256'(wr_cmd_addr), 256'(cur.addr));
            chk("cmd_len", 256'(wr_cmd_len), 256'(BL-1));
            chk("prefetch_addr", 256'(ch_rd_addr), 256'(cur.half) * 256'(BL));
            chk("cmd_rd_valid", 256'(ch_rd_valid), 256'(4'b1 << cur.ch));
          end
        end
      end
      p_cmd_stall = wr_cmd_valid && !wr_cmd_ready; p_addr = wr_cmd_addr;
      if (p_dat_stall) chk("data_valid_held", 256'(wr_data_valid), 256'(1));
      if (wr_data_valid) begin
        if (!have_cur) chk("unexpected_data", 256'(wr_data_valid), 256'(0));
        else begin
          chk("data_rd_valid", 256'(ch_rd_valid), 256'(4'b1 << cur.ch));
          if (p_dat_stall) chk("data_stable", wr_data, p_data);
          chk("data_last", 256'(wr_data_last), 256'(mon_beat == BL-1));
          if (wr_data_ready) begin
            chk("beat_data", wr_data, mem[cur.ch][int'(cur.half)*BL + mon_beat]);
            mon_beat++;
            if (mon_beat == BL) begin have_cur = 0; bursts_done++; end
          end
        end
      end
      p_dat_stall = wr_data_valid && !wr_data_ready; p_data = wr_data;
    end
  end

  // Burst-level model: one sweep from rr serves every requested channel once.
  task automatic model_round(input logic [3:0] mask);
    int idx;
    int base = m_rr;
    for (int k = 0; k < 4; k++) begin
      idx = (base + k) % 4;
      if (mask[idx]) begin
        expq.push_back('{ch: 2'(idx), addr: 28'(idx) * REG + 28'(m_off[idx]), half: m_half[idx]});
        bursts_exp++;
        m_half[idx] = !m_half[idx];
        if (m_fp[idx]) begin m_off[idx] = 0; m_fp[idx] = 0; exp_wrap[idx]++; end
        else begin
          m_off[idx] += BL;
          if (m_off[idx] >= int'(REG)) begin m_off[idx] = 0; exp_wrap[idx]++; end
        end
        m_rr = (idx + 1) % 4;
      end
    end
  endtask

  task automatic wait_bursts();
    int t = 0;
    while (bursts_done < bursts_exp && t < 4000) begin @(negedge clk_in); t++; end
    if (bursts_done < bursts_exp) begin
      chk("burst_timeout", 256'(bursts_done), 256'(bursts_exp));
      expq.delete(); bursts_exp = bursts_done;
    end
  endtask

  task automatic round(input logic [3:0] mask, input int mode, input logic [3:0] fe_pre, input bit fe_mid);
    int t = 0;
    bp_mode = mode;
    @(posedge clk_in); #1 ch_ready = mask; ch_frame_end = fe_pre;
    @(posedge clk_in); #1 ch_ready = '0; ch_frame_end = '0;
    for (int i = 0; i < 4; i++) if (fe_pre[i]) m_fp[i] = 1;
    if (fe_mid) m_fp[1] = 1;
    repeat (3) begin @(negedge clk_in); chk("blocked_no_cmd", 256'(wr_cmd_valid), 256'(0)); end
    model_round(mask);
    cfg_en = 1'b1;
    if (fe_mid) begin
      while (!wr_data_valid && t < 200) begin @(negedge clk_in); t++; end
      @(posedge clk_in); @(posedge clk_in); #1 ch_frame_end = 4'b0010;
      @(posedge clk_in); #1 ch_frame_end = '0;
    end
    wait_bursts();
    cfg_en = 1'b0;
    repeat (3) @(negedge clk_in);
    for (int i = 0; i < 4; i++) chk("wrap_count", 256'(wrap_cnt[i]), 256'(exp_wrap[i]));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    for (int i = 0; i < 4; i++) begin
      m_off[i] = 0; m_half[i] = 0; m_fp[i] = 0; exp_wrap[i] = 0; wrap_cnt[i] = 0;
      for (int a = 0; a < 32; a++)
        for (int w = 0; w < 8; w++) mem[i][a][w*32 +: 32] = $urandom;
    end
    repeat (3) @(negedge clk_in);
    chk("rst_cmd_valid", 256'(wr_cmd_valid), 256'(0));
    chk("rst_data_valid", 256'(wr_data_valid), 256'(0));
    chk("rst_rd_valid", 256'(ch_rd_valid), 256'(0));
    chk("rst_grant", 256'(grant_id), 256'(0));
    @(posedge clk_in); #1 rst = 1'b1;

    round(4'b0100, 0, 4'b0000, 0);       // single channel, full throughput
    round(4'b1111, 0, 4'b0000, 0);       // all four in rr order
    round(4'b0001, 0, 4'b0000, 0);       // ch0 second half
    round(4'b0010, 2, 4'b0000, 0);       // toggling data ready, held-off command
    round(4'b0010, 0, 4'b0000, 1);       // frame end mid-burst
    round(4'b0010, 0, 4'b0000, 0);
    repeat (16) round(4'b1000, 0, 4'b0000, 0);  // ch3 walks to the region end
    repeat (30) round(4'($urandom_range(1, 15)), int'($urandom_range(0, 1)),
                      (($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000), 0);

    // Reset in the middle of a burst
    bp_mode = 0;
    @(posedge clk_in); #1 ch_ready = 4'b0100;
    @(posedge clk_in); #1 ch_ready = '0;
    model_round(4'b0100);
    cfg_en = 1'b1;
    t = 0;
    while (mon_beat != 7 && t < 200) begin @(negedge clk_in); t++; end
    chk("reached_beat7", 256'(mon_beat), 256'(7));
    @(posedge clk_in); #2 rst = 1'b0;
    #1;
    chk("mrst_cmd_valid", 256'(wr_cmd_valid), 256'(0));
    chk("mrst_data_valid", 256'(wr_data_valid), 256'(0));
    chk("mrst_rd_valid", 256'(ch_rd_valid), 256'(0));
    chk("mrst_last", 256'(wr_data_last), 256'(0));
    chk("mrst_data", wr_data, 256'(0));
    chk("mrst_rd_addr", 256'(ch_rd_addr), 256'(0));
    chk("mrst_cmd_addr", 256'(wr_cmd_addr), 256'(0));
    chk("mrst_grant", 256'(grant_id), 256'(0));
    chk("mrst_frame_wrap", 256'(frame_wrap), 256'(0));
    expq.delete(); bursts_exp = bursts_done; cfg_en = 1'b0;
    m_rr = 0;
    for (int i = 0; i < 4; i++) begin m_off[i] = 0; m_half[i] = 0; m_fp[i] = 0; end
    @(posedge clk_in); #1 rst = 1'b1;

    round(4'b0101, 0, 4'b0000, 0);       // blocked pend, then ch0 and ch2
    round(4'($urandom_range(1, 15)), 1, 4'b0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
